obuf_data_packer: RTL and testbench
===================================

// Module: obuf_data_packer
// PURPOSE
//   Write-back counterpart of the input-buffer shuffler. Each cycle the output buffer presents one
//   row: one DATA_WIDTH element per bank. The block collects RATIO rows and interleaves them into
//   one DDR_BANDWIDTH word, row i filling slice i. Sits between output-buffer bank reads and the
//   DDR write-data channel.
//   It has valid/ready handshakes on both sides, a one-word output holding register, and an
//   explicit flush for partial words.
// PARAMETERS
//   DDR_BANDWIDTH  512  DDR write word width in bits
//   NUM_BANKS      8    output-buffer banks (elements per row)
//   DATA_WIDTH     8    element width in bits
//   RATIO          DDR_BANDWIDTH/(NUM_BANKS*DATA_WIDTH) = 8   rows per DDR word (derived, do not override)
// PORTS
//   clk            in   1                       clock; all logic on rising edge
//   rstn           in   1                       reset, synchronous, active-low
//   bank_data_in   in   NUM_BANKS*DATA_WIDTH    row; element j = bits [(j+1)*DW-1 : j*DW] = bank j
//   bank_valid     in   1                       row valid
//   bank_ready     out  1                       row accepted when bank_valid && bank_ready
//   flush          in   1                       level request: emit partial word; hold until flush_done
//   flush_done     out  1                       one-cycle pulse: flush completed
//   ddr_data_out   out  DDR_BANDWIDTH           packed word
//   ddr_strb       out  RATIO                   bit i = slice i holds a valid row
//   ddr_valid      out  1                       word valid; held until ddr_ready
//   ddr_ready      in   1                       word taken when ddr_valid && ddr_ready
// BEHAVIOUR
//   - Packing: row i (0..RATIO-1) element j -> ddr_data_out[i*NB*DW + (j+1)*DW-1 : i*NB*DW + j*DW].
//   - State: beat counter cnt (0..RATIO-1), accumulation register acc, output register (data/strb/valid).
//   - Reset (rstn=0 at edge): cnt=0, acc=0, ddr_valid=0, ddr_data_out=0, ddr_strb=0, flush_done=0.
//     Reset mid-word discards the partial rows.
//   - slot_free = !ddr_valid || ddr_ready.
//   - bank_ready = !flush && (cnt != RATIO-1 || slot_free). Combinational.
//     bank_ready is 1 out of reset when flush=0.
//   - Row accepted with cnt < RATIO-1: write slice cnt of acc; cnt++.
//   - Row accepted with cnt == RATIO-1:
//     - output register <= acc merged with the row; ddr_strb = all ones; ddr_valid=1 next cycle.
//     - cnt=0; acc cleared.
//   - Latency: the final row is accepted in cycle N; ddr_valid is asserted in cycle N+1.
//   - Throughput: 1 row/cycle sustained with ddr_ready=1, no bubbles.
//   - Output register: data and strb stay stable while ddr_valid && !ddr_ready.
//     On handshake with no new load, ddr_valid=0 next cycle; data is don't-care.
//   - Flush (flush=1): no rows accepted. Completes on the first cycle with slot_free:
//     - cnt>0: output register <= acc; unfilled slices zero; ddr_strb = (1<<cnt)-1; ddr_valid=1.
//       Then cnt=0 and acc cleared.
//     - cnt==0: no word is emitted.
//     - flush_done=1 in the cycle after completion. Upstream drops flush after flush_done.
//       A still-high flush then starts a new, trivial flush.
//   - Load and drain in the same cycle: a new word may load in the same cycle the old word
//     handshakes; ddr_valid stays 1.
// TESTING
//   - Full word: 8 rows, row i element j = {i[3:0],j[3:0]}, ddr_ready=1.
//     -> byte (i*8+j) of ddr_data_out = 8'h{i}{j}; strb=8'hFF; ddr_valid the cycle after row 7.
//   - Backpressure: word pending with ddr_ready=0; push the next word.
//     -> rows 0-6 accepted, row 7 stalls (bank_ready=0), output data stable.
//     -> raise ddr_ready: first word taken, second word valid the next cycle.
//   - Partial flush: 3 rows, then flush.
//     -> ddr_strb=8'h07, slices 3-7 zero, flush_done pulses once.
//     -> the next row lands in slice 0.
//   - Empty flush: flush with cnt=0 -> flush_done the next cycle, ddr_valid never asserts.
//   - Reset mid-word: 4 rows, rstn=0 for 1 cycle, then 8 rows.
//     -> exactly one word containing only the post-reset rows.
//   - Streaming: 64 rows back-to-back, ddr_ready=1.
//     -> 8 words; bank_ready never deasserts; one word every 8 cycles.

Source files
------------

// File: rtl/obuf_data_packer.sv
// Packs RATIO output-buffer rows into one DDR write word, row i in slice i,
// behind a single-word output register with flush support for partial words.
module obuf_data_packer #(
  parameter int DDR_BANDWIDTH = 512,
  parameter int NUM_BANKS     = 8,
  parameter int DATA_WIDTH    = 8,
  localparam int RATIO        = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]   bank_data_in,
  input  logic                              bank_valid,
  output logic                              bank_ready,
  input  logic                              flush,
  output logic                              flush_done,
  output logic [DDR_BANDWIDTH-1:0]          ddr_data_out,
  output logic [RATIO-1:0]                  ddr_strb,
  output logic                              ddr_valid,
  input  logic                              ddr_ready
);

  localparam int ROW_W = NUM_BANKS * DATA_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]         cnt;
  logic [DDR_BANDWIDTH-1:0] acc;
  logic [DDR_BANDWIDTH-1:0] merged;
  logic [RATIO-1:0]         part_strb;
  logic                     slot_free;
  logic                     accept;
  logic                     flush_fire;

  // Only the final row of a word needs the output slot; earlier rows go to acc.
  always_comb begin
    slot_free  = !ddr_valid || ddr_ready;
    bank_ready = !flush && (cnt != LAST || slot_free);
    accept     = bank_valid && bank_ready;
    flush_fire = flush && slot_free;
  end

  always_comb begin
    merged = acc;
    merged[32'(cnt) * ROW_W +: ROW_W] = bank_data_in;
  end

  always_comb begin
    part_strb = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      part_strb[i] = (i < 32'(cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt          <= '0;
      acc          <= '0;
      ddr_valid    <= 1'b0;
      ddr_data_out <= '0;
      ddr_strb     <= '0;
      flush_done   <= 1'b0;
    end else begin
      flush_done <= flush_fire;
      if (ddr_valid && ddr_ready) begin
        ddr_valid <= 1'b0;
      end
      // A load in the same cycle as a drain overrides the clear above.
      if (accept) begin
        if (cnt == LAST) begin
          ddr_data_out <= merged;
          ddr_strb     <= '1;
          ddr_valid    <= 1'b1;
          cnt          <= '0;
          acc          <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt + 1'b1;
        end
      end else if (flush_fire && cnt != '0) begin
        ddr_data_out <= acc;
        ddr_strb     <= part_strb;
        ddr_valid    <= 1'b1;
        cnt          <= '0;
        acc          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_obuf_data_packer.sv
// Bench for obuf_data_packer: cycle model with word scoreboard, a vector table
// for the basic full word, and directed sequences for flush, stall and reset.
module tb_obuf_data_packer;

  localparam int DDR_BW = 512;
  localparam int NB     = 8;
  localparam int DW     = 8;
  localparam int RATIO  = 8;
  localparam int ROW_W  = NB * DW;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [ROW_W-1:0]  bank_data_in = '0;
  logic              bank_valid = 1'b0;
  logic              bank_ready;
  logic              flush = 1'b0;
  logic              flush_done;
  logic [DDR_BW-1:0] ddr_data_out;
  logic [RATIO-1:0]  ddr_strb;
  logic              ddr_valid;
  logic              ddr_ready = 1'b1;

  always #5 clk = ~clk;

  obuf_data_packer #(
    .DDR_BANDWIDTH(DDR_BW),
    .NUM_BANKS    (NB),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bank_data_in(bank_data_in),
    .bank_valid  (bank_valid),
    .bank_ready  (bank_ready),
    .flush       (flush),
    .flush_done  (flush_done),
    .ddr_data_out(ddr_data_out),
    .ddr_strb    (ddr_strb),
    .ddr_valid   (ddr_valid),
    .ddr_ready   (ddr_ready)
  );

  typedef struct {
    logic [DDR_BW-1:0] data;
    logic [RATIO-1:0]  strb;
  } word_t;

  typedef struct {
    logic valid;
    logic rdy;
    logic exp_bank_ready;
    logic exp_ddr_valid;
  } vec_t;

  word_t sb[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  int                m_cnt = 0;
  logic [DDR_BW-1:0] m_acc = '0;
  logic              m_valid = 1'b0;
  logic              m_fd = 1'b0;
  logic              last_accept = 1'b0;

  // values sampled at the falling edge of the last tick
  logic              s_bank_ready;
  logic              s_ddr_valid;
  logic [DDR_BW-1:0] s_data;

  int words_out = 0;
  int fd_pulses = 0;
  int stream_stalls = 0;
  logic streaming = 1'b0;

  task automatic check(input string name, input logic [DDR_BW-1:0] act,
                       input logic [DDR_BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row(input int w, input int i);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < NB; j++) begin
      r[j*DW +: DW] = {4'(i), 4'(j)} ^ 8'(w * 37);
    end
    return r;
  endfunction

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic tick();
    logic exp_ready, accept, fire, hs;
    @(negedge clk);
    s_bank_ready = bank_ready;
    s_ddr_valid  = ddr_valid;
    s_data       = ddr_data_out;
    exp_ready = !flush && (m_cnt != RATIO - 1 || !m_valid || ddr_ready);
    check("bank_ready", bank_ready, exp_ready);
    check("ddr_valid", ddr_valid, m_valid);
    check("flush_done", flush_done, m_fd);
    if (flush_done === 1'b1) fd_pulses++;
    if (streaming && bank_ready !== 1'b1) stream_stalls++;
    if (m_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: word expected but queue empty");
      end else begin
        check("ddr_data", ddr_data_out, sb[0].data);
        check("ddr_strb", ddr_strb, sb[0].strb);
      end
    end
    hs = m_valid && ddr_ready;
    if (hs && sb.size() > 0) begin
      void'(sb.pop_front());
      words_out++;
    end
    accept = bank_valid && exp_ready;
    fire   = flush && (!m_valid || ddr_ready);
    if (!rstn) begin
      m_cnt = 0; m_acc = '0; m_valid = 1'b0; m_fd = 1'b0;
      sb.delete();
      accept = 1'b0;
    end else begin
      m_fd = fire;
      if (hs) m_valid = 1'b0;
      if (accept) begin
        m_acc[m_cnt*ROW_W +: ROW_W] = bank_data_in;
        if (m_cnt == RATIO - 1) begin
          sb.push_back('{m_acc, {RATIO{1'b1}}});
          m_valid = 1'b1; m_cnt = 0; m_acc = '0;
        end else begin
          m_cnt++;
        end
      end else if (fire && m_cnt != 0) begin
        sb.push_back('{m_acc, RATIO'((1 << m_cnt) - 1)});
        m_valid = 1'b1; m_cnt = 0; m_acc = '0;
      end
    end
    last_accept = accept;
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [ROW_W-1:0] d);
    bit done = 0;
    bank_valid   = 1'b1;
    bank_data_in = d;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (last_accept) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_row_timeout: row not accepted within 20 cycles");
    end
  endtask

  vec_t tbl[10];
  logic [DDR_BW-1:0] hold;
  logic [DDR_BW-1:0] exp_bytes;
  int w0;

  initial begin
    for (int k = 0; k < 10; k++) begin
      tbl[k] = '{valid: (k < 8), rdy: 1'b1, exp_bank_ready: 1'b1, exp_ddr_valid: (k == 8)};
    end
    for (int i = 0; i < RATIO; i++)
      for (int j = 0; j < NB; j++)
        exp_bytes[(i*NB+j)*DW +: DW] = {4'(i), 4'(j)};

    // reset
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_ddr_valid", ddr_valid, 0);
    check("rst_ddr_data", ddr_data_out, 0);
    check("rst_ddr_strb", ddr_strb, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_bank_ready", bank_ready, 1);

    // full word from the vector table
    for (int k = 0; k < 10; k++) begin
      bank_valid   = tbl[k].valid;
      bank_data_in = row(0, k);
      ddr_ready    = tbl[k].rdy;
      tick();
      check("tbl_bank_ready", s_bank_ready, tbl[k].exp_bank_ready);
      check("tbl_ddr_valid", s_ddr_valid, tbl[k].exp_ddr_valid);
      if (k == 8) check("full_word_bytes", s_data, exp_bytes);
    end

    // empty flush
    flush = 1'b1;
    tick();
    check("empty_flush_done", flush_done, 1);
    check("empty_flush_valid", ddr_valid, 0);
    flush = 1'b0;
    tick();
    tick();

    // partial flush, then next row lands in slice 0
    for (int i = 0; i < 3; i++) send_row(row(1, i));
    bank_valid = 1'b0;
    flush = 1'b1;
    fd_pulses = 0;
    begin
      bit done = 0;
      for (int k = 0; k < 10 && !done; k++) begin
        tick();
        if (m_fd) done = 1;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL flush_timeout: flush_done not seen");
      end
    end
    flush = 1'b0;
    check("pflush_done", flush_done, 1);
    check("pflush_strb", ddr_strb, 8'h07);
    check("pflush_upper_zero", ddr_data_out[DDR_BW-1:3*ROW_W], 0);
    tick();
    tick();
    check("pflush_pulse_count", fd_pulses, 1);
    for (int i = 0; i < RATIO; i++) send_row(row(4, i));
    bank_valid = 1'b0;
    tick();
    tick();

    // backpressure: word A pending, word B stalls on its last row
    ddr_ready = 1'b0;
    for (int i = 0; i < RATIO; i++) send_row(row(2, i));
    for (int i = 0; i < RATIO - 1; i++) send_row(row(3, i));
    bank_data_in = row(3, RATIO - 1);
    bank_valid   = 1'b1;
    hold = ddr_data_out;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_bank_ready", s_bank_ready, 0);
      check("stall_data_stable", s_data, hold);
    end
    ddr_ready = 1'b1;
    tick();
    check("drain_load_valid", ddr_valid, 1);
    bank_valid = 1'b0;
    tick();
    tick();

    // reset mid-word
    for (int i = 0; i < 4; i++) send_row(row(5, i));
    bank_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    w0 = words_out;
    for (int i = 0; i < RATIO; i++) send_row(row(6, i));
    bank_valid = 1'b0;
    repeat (3) tick();
    check("reset_word_count", words_out - w0, 1);

    // streaming
    w0 = words_out;
    stream_stalls = 0;
    streaming = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bank_valid   = 1'b1;
      bank_data_in = {$urandom, $urandom};
      tick();
    end
    streaming = 1'b0;
    bank_valid = 1'b0;
    repeat (3) tick();
    check("stream_words", words_out - w0, 8);
    check("stream_stalls", stream_stalls, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
